// File: rtl/mercury_seg_scan.sv
// mercury_seg_scan: time-multiplexed driver for NUM_DIGITS common-anode
// seven-segment digits. Each digit shows a decoded hex nibble or a raw
// pattern, with a per-digit dot and blank, PWM brightness and a dead time
// at the start of every dwell that stops ghosting between digits.
// Optional build macro: LEADING_ZERO_BLANK_EN. When it is defined and the
// display is in hex mode, leading zero digits are blanked automatically.
module mercury_seg_scan #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 12500,
    parameter int DEAD_CYCLES  = 64,
    parameter int BRIGHT_W     = 4
) (
    input  logic                    app_clk,
    input  logic                    app_srst,
    input  logic                    enable,
    input  logic                    raw_mode,
    input  logic [4*NUM_DIGITS-1:0] hex_in,
    input  logic [7*NUM_DIGITS-1:0] seg_raw_in,
    input  logic [NUM_DIGITS-1:0]   dots_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic [BRIGHT_W-1:0]     bright,
    output logic [NUM_DIGITS-1:0]   AN_out,
    output logic [6:0]              A_TO_G_out,
    output logic                    DOTS_out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DW_W  = $clog2(DWELL_CYCLES);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [DW_W-1:0]  DEAD_V     = DW_W'(DEAD_CYCLES);
    localparam logic [IDX_W-1:0] DIGIT_LAST = IDX_W'(NUM_DIGITS - 1);

    // Scan counters
    logic [DW_W-1:0]     r_dwell_cnt;
    logic [IDX_W-1:0]    r_digit_idx;
    logic [BRIGHT_W-1:0] r_pwm_cnt;

    // Per-dwell snapshot of the selected digit
    logic [3:0]          r_snap_hex;
    logic [6:0]          r_snap_raw;
    logic                r_snap_dot;
    logic                r_snap_blank;
    logic                r_snap_rawmode;
    logic [BRIGHT_W-1:0] r_snap_bright;

    // Per-digit views of the packed input buses
    logic [3:0] w_hex_arr [NUM_DIGITS];
    logic [6:0] w_raw_arr [NUM_DIGITS];
    logic       w_lz      [NUM_DIGITS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign w_hex_arr[gi] = hex_in[4*gi +: 4];
            assign w_raw_arr[gi] = seg_raw_in[7*gi +: 7];
`ifdef LEADING_ZERO_BLANK_EN
            // A digit is a leading zero when it and every digit to its left are zero
            if (gi == 0) begin : g_lz0
                assign w_lz[gi] = 1'b0;
            end else begin : g_lzn
                assign w_lz[gi] = ~raw_mode
                                & (hex_in[4*NUM_DIGITS-1:4*gi] == '0)
                                & ~dots_in[gi];
            end
`else
            assign w_lz[gi] = 1'b0;
`endif
        end
    endgenerate

    // Live values for the currently selected digit
    logic [3:0] w_live_hex;
    logic [6:0] w_live_raw;
    logic       w_live_dot;
    logic       w_live_blank;
    assign w_live_hex   = w_hex_arr[r_digit_idx];
    assign w_live_raw   = w_raw_arr[r_digit_idx];
    assign w_live_dot   = dots_in[r_digit_idx];
    assign w_live_blank = blank_in[r_digit_idx] | w_lz[r_digit_idx];

    // On the capture cycle itself the snapshot is not loaded yet, so use the
    // live values; this matters only when DEAD_CYCLES is zero.
    logic                w_cap;
    logic [3:0]          w_cur_hex;
    logic [6:0]          w_cur_raw;
    logic                w_cur_dot;
    logic                w_cur_blank;
    logic                w_cur_rawmode;
    logic [BRIGHT_W-1:0] w_cur_bright;
    assign w_cap         = (r_dwell_cnt == '0);
    assign w_cur_hex     = w_cap ? w_live_hex   : r_snap_hex;
    assign w_cur_raw     = w_cap ? w_live_raw   : r_snap_raw;
    assign w_cur_dot     = w_cap ? w_live_dot   : r_snap_dot;
    assign w_cur_blank   = w_cap ? w_live_blank : r_snap_blank;
    assign w_cur_rawmode = w_cap ? raw_mode     : r_snap_rawmode;
    assign w_cur_bright  = w_cap ? bright       : r_snap_bright;

    // Hex nibble to segment pattern, bit 6 = A .. bit 0 = G
    logic [6:0] w_dec;
    always_comb begin
        w_dec = 7'b0000000;
        case (w_cur_hex)
            4'h0: w_dec = 7'b1111110;
            4'h1: w_dec = 7'b0110000;
            4'h2: w_dec = 7'b1101101;
            4'h3: w_dec = 7'b1111001;
            4'h4: w_dec = 7'b0110011;
            4'h5: w_dec = 7'b1011011;
            4'h6: w_dec = 7'b1011111;
            4'h7: w_dec = 7'b1110000;
            4'h8: w_dec = 7'b1111111;
            4'h9: w_dec = 7'b1111011;
            4'hA: w_dec = 7'b1110111;
            4'hB: w_dec = 7'b0011111;
            4'hC: w_dec = 7'b1001110;
            4'hD: w_dec = 7'b0111101;
            4'hE: w_dec = 7'b1001111;
            4'hF: w_dec = 7'b1000111;
            default: w_dec = 7'b0000000;
        endcase
    end

    logic                  w_lit;
    logic [6:0]            w_seg;
    logic [NUM_DIGITS-1:0] w_an_sel;
    assign w_lit    = (r_dwell_cnt >= DEAD_V) & ~w_cur_blank & (r_pwm_cnt < w_cur_bright);
    assign w_seg    = w_cur_rawmode ? w_cur_raw : w_dec;
    assign w_an_sel = ~(NUM_DIGITS'(1) << r_digit_idx);

    // Scan counters, snapshot capture and registered pin drive
    always_ff @(posedge app_clk) begin
        if (app_srst) begin
            r_dwell_cnt    <= '0;
            r_digit_idx    <= '0;
            r_pwm_cnt      <= '0;
            r_snap_hex     <= '0;
            r_snap_raw     <= '0;
            r_snap_dot     <= 1'b0;
            r_snap_blank   <= 1'b0;
            r_snap_rawmode <= 1'b0;
            r_snap_bright  <= '0;
            AN_out         <= '1;
            A_TO_G_out     <= '0;
            DOTS_out       <= 1'b0;
        end else if (!enable) begin
            r_dwell_cnt <= '0;
            r_digit_idx <= '0;
            r_pwm_cnt   <= '0;
            AN_out      <= '1;
            A_TO_G_out  <= '0;
            DOTS_out    <= 1'b0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            if (r_dwell_cnt == DWELL_LAST) begin
                r_dwell_cnt <= '0;
                r_digit_idx <= (r_digit_idx == DIGIT_LAST) ? '0 : r_digit_idx + 1'b1;
            end else begin
                r_dwell_cnt <= r_dwell_cnt + 1'b1;
            end
            if (w_cap) begin
                r_snap_hex     <= w_live_hex;
                r_snap_raw     <= w_live_raw;
                r_snap_dot     <= w_live_dot;
                r_snap_blank   <= w_live_blank;
                r_snap_rawmode <= raw_mode;
                r_snap_bright  <= bright;
            end
            AN_out     <= w_lit ? w_an_sel  : '1;
            A_TO_G_out <= w_lit ? w_seg     : '0;
            DOTS_out   <= w_lit ? w_cur_dot : 1'b0;
        end
    end

endmodule

// File: tb/tb_mercury_seg_scan.sv
// Testbench for mercury_seg_scan with NUM_DIGITS=4, DWELL_CYCLES=8,
// DEAD_CYCLES=2, BRIGHT_W=2. Pins are compared every cycle against the
// behaviour expected from the counter state one cycle earlier, plus a few
// hand-computed spot checks.
module tb_mercury_seg_scan;

    localparam int ND = 4;

    logic          app_clk = 1'b0;
    logic          app_srst;
    logic          enable;
    logic          raw_mode;
    logic [15:0]   hex_in;
    logic [27:0]   seg_raw_in;
    logic [3:0]    dots_in;
    logic [3:0]    blank_in;
    logic [1:0]    bright;
    logic [3:0]    AN_out;
    logic [6:0]    A_TO_G_out;
    logic          DOTS_out;

    int errors = 0;
    int checks = 0;

    mercury_seg_scan #(
        .NUM_DIGITS(4), .DWELL_CYCLES(8), .DEAD_CYCLES(2), .BRIGHT_W(2)
    ) dut (
        .app_clk(app_clk), .app_srst(app_srst), .enable(enable),
        .raw_mode(raw_mode), .hex_in(hex_in), .seg_raw_in(seg_raw_in),
        .dots_in(dots_in), .blank_in(blank_in), .bright(bright),
        .AN_out(AN_out), .A_TO_G_out(A_TO_G_out), .DOTS_out(DOTS_out)
    );

    always #5 app_clk = ~app_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
            4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
            4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
            4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
            4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
            4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
            4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
            4'hE: return 7'b1001111;  default: return 7'b1000111;
        endcase
    endfunction

    // Cycle index since the scan last restarted, and the values the display
    // latched at the start of the current dwell
    int         k = 0;
    logic [6:0] m_seg;
    logic       m_dot;
    logic       m_blank;
    logic [1:0] m_bright;

    // Advance n clock edges, checking the pins after each edge
    task automatic cyc(input int n);
        for (int c = 0; c < n; c++) begin
            int         d;
            logic       lit;
            logic [3:0] exp_an;
            logic [6:0] exp_seg;
            logic       exp_dot;
            d = (k / 8) % ND;
            if (!app_srst && enable && (k % 8 == 0)) begin
                m_seg    = raw_mode ? seg_raw_in[7*d +: 7] : seg_of(hex_in[4*d +: 4]);
                m_dot    = dots_in[d];
                m_blank  = blank_in[d];
`ifdef LEADING_ZERO_BLANK_EN
                if (!raw_mode && d > 0 && ((hex_in >> (4*d)) == 16'h0) && !dots_in[d])
                    m_blank = 1'b1;
`endif
                m_bright = bright;
            end
            lit = !app_srst && enable && (k % 8 >= 2) && !m_blank && ((k % 4) < int'(m_bright));
            exp_an  = lit ? ~(4'b0001 << d) : 4'b1111;
            exp_seg = lit ? m_seg : 7'b0;
            exp_dot = lit ? m_dot : 1'b0;
            @(posedge app_clk);
            #1;
            check("an",  32'(AN_out),     32'(exp_an));
            check("seg", 32'(A_TO_G_out), 32'(exp_seg));
            check("dot", 32'(DOTS_out),   32'(exp_dot));
            $display("k=%0d digit=%0d AN=%b SEG=%b DOT=%b", k, d, AN_out, A_TO_G_out, DOTS_out);
            if (app_srst || !enable) k = 0;
            else k++;
        end
    endtask

    initial begin
        app_srst = 1'b1; enable = 1'b0; raw_mode = 1'b0; hex_in = 16'h0;
        seg_raw_in = '0; dots_in = 4'b0; blank_in = 4'b0; bright = 2'd0;
        m_seg = '0; m_dot = 1'b0; m_blank = 1'b0; m_bright = 2'd0;
        @(negedge app_clk);

        // Reset held then released with the scan disabled
        cyc(3);
        check("rst_an", 32'(AN_out), 32'hF);
        app_srst = 1'b0;
        cyc(4);

        // Hex scan of 1234 at full brightness
        enable = 1'b1; bright = 2'd3; hex_in = 16'h1234;
        cyc(3);
        check("t2_first_an",  32'(AN_out),     32'(4'b1110));
        check("t2_first_seg", 32'(A_TO_G_out), 32'(7'b0110011));
        cyc(29);

        // Input change in the middle of digit1's dwell
        cyc(12);
        hex_in = 16'hABCD;
        cyc(3);
        check("t4_hold_an",  32'(AN_out),     32'(4'b1101));
        check("t4_hold_seg", 32'(A_TO_G_out), 32'(7'b1111001));
        cyc(17);
        cyc(32);

        // Raw mode with a dot on digit2, after a disable/enable restart
        enable = 1'b0;
        cyc(2);
        raw_mode = 1'b1; dots_in = 4'b0100;
        seg_raw_in = {7'b0001111, 7'b1010101, 7'b1100110, 7'b0110110};
        enable = 1'b1;
        cyc(19);
        check("t3_d2_an",  32'(AN_out),     32'(4'b1011));
        check("t3_d2_seg", 32'(A_TO_G_out), 32'(7'b1010101));
        check("t3_d2_dot", 32'(DOTS_out),   32'(1'b1));
        cyc(13);

        // Forced blank on digit1
        blank_in = 4'b0010;
        cyc(32);
        blank_in = 4'b0000;

        // Brightness 0 then minimum brightness
        raw_mode = 1'b0; dots_in = 4'b0; hex_in = 16'h1234; bright = 2'd0;
        cyc(64);
        bright = 2'd1;
        cyc(32);

        // Leading zeros
        hex_in = 16'h0050; bright = 2'd3;
        cyc(32);

        // Reset in the middle of a dwell
        cyc(5);
        app_srst = 1'b1;
        cyc(1);
        app_srst = 1'b0;
        cyc(16);

        // Disable goes dark on the next edge
        enable = 1'b0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
